// File: rtl/dti_pack.sv
// rtl/dti_pack.sv - shared defaults, state enum and payload width helper for the DTI<->NoC converter
package dti_pack;

  localparam int DTI_DATA_W = 80;
  localparam int DTI_TID_W  = 6;
  localparam int NOC_NODE_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } conv_state_e;

  // NoC payload carries tdata followed by one keep bit per data byte
  function automatic int payload_w(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/dti_conv_fifo.sv
// rtl/dti_conv_fifo.sv - valid/ready FIFO with wrap-bit pointers and 1-cycle write-to-head latency
module dti_conv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  // Full blocks a write even if the head is popped the same cycle
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign push       = push_valid && !full;
  assign pop        = pop_ready && !empty;
  assign pop_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dti_gnpd_conv_pipe.sv
// rtl/dti_gnpd_conv_pipe.sv - registered DTI<->NoC converter with packet-atomic injection and srcid checking
module dti_gnpd_conv_pipe
  import dti_pack::*;
#(
  parameter int   DATA_W     = DTI_DATA_W,
  parameter int   TID_W      = DTI_TID_W,
  parameter int   NODE_W     = NOC_NODE_W,
  parameter int   REQ_DEPTH  = 4,
  parameter int   RSP_DEPTH  = 4,
  parameter int   RSP_THRESH = 2,
  parameter logic REQ_QOS    = 1'b1,
  localparam int  KEEP_W     = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NODE_W-1:0]        cfg_tgtid,
  input  logic                     req_tvalid,
  output logic                     req_tready,
  input  logic [DATA_W-1:0]        req_tdata,
  input  logic [KEEP_W-1:0]        req_tkeep,
  input  logic                     req_tlast,
  input  logic [TID_W-1:0]         req_ttid,
  output logic                     rsp_tvalid,
  input  logic                     rsp_tready,
  output logic [DATA_W-1:0]        rsp_tdata,
  output logic [KEEP_W-1:0]        rsp_tkeep,
  output logic                     rsp_tlast,
  output logic [TID_W-1:0]         rsp_ttid,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [DATA_W+KEEP_W-1:0] req_payload,
  output logic [TID_W-1:0]         req_srcid,
  output logic [NODE_W-1:0]        req_tgtid,
  output logic                     req_qos,
  output logic                     req_last,
  input  logic                     req_threshold,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [DATA_W+KEEP_W-1:0] rsp_payload,
  input  logic [TID_W-1:0]         rsp_srcid,
  input  logic [NODE_W-1:0]        rsp_tgtid,
  input  logic                     rsp_qos,
  input  logic                     rsp_last,
  output logic                     rsp_threshold,
  output logic                     err_tid
);

  localparam int PW     = payload_w(DATA_W);
  localparam int REQ_EW = PW + TID_W + 1 + NODE_W;
  localparam int RSP_EW = PW + TID_W + 1;
  localparam int QAW    = $clog2(REQ_DEPTH);
  localparam int RAW    = $clog2(RSP_DEPTH);
  // (RSP_DEPTH - count) >= RSP_THRESH rewritten as a bound on count
  localparam logic [RAW:0] THR_LIMIT = (RAW+1)'(RSP_DEPTH - RSP_THRESH);

  logic [REQ_EW-1:0] req_head;
  logic              req_nonempty;
  logic              req_full_unused;
  logic              req_empty_unused;
  logic [QAW:0]      req_count_unused;
  conv_state_e       req_state;
  conv_state_e       req_state_d;

  assign req_qos = REQ_QOS;

  dti_conv_fifo #(.WIDTH(REQ_EW), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (req_tvalid),
    .push_ready (req_tready),
    .push_data  ({req_tdata, req_tkeep, req_ttid, req_tlast, cfg_tgtid}),
    .pop_valid  (req_nonempty),
    .pop_ready  (req_valid && req_ready),
    .pop_data   (req_head),
    .full       (req_full_unused),
    .empty      (req_empty_unused),
    .count      (req_count_unused)
  );

  assign {req_payload, req_srcid, req_last, req_tgtid} = req_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_state <= IDLE;
    else        req_state <= req_state_d;
  end

  // Threshold only gates the first beat; inside a packet it is ignored
  always_comb begin
    req_state_d = req_state;
    req_valid   = 1'b0;
    case (req_state)
      IDLE: begin
        req_valid = req_nonempty && req_threshold;
        if (req_valid && req_ready && !req_last) req_state_d = BURST;
      end
      BURST: begin
        req_valid = req_nonempty;
        if (req_valid && req_ready && req_last) req_state_d = IDLE;
      end
    endcase
  end

  logic [RSP_EW-1:0] rsp_head;
  logic [PW-1:0]     rsp_head_payload;
  logic              rsp_full_unused;
  logic              rsp_empty_unused;
  logic [RAW:0]      rsp_count;
  logic [RAW:0]      rsp_count_d;
  logic              rsp_push;
  logic              rsp_pop;
  conv_state_e       rsp_state;
  conv_state_e       rsp_state_d;
  logic [TID_W-1:0]  rsp_src_q;
  logic [TID_W-1:0]  rsp_src_d;
  logic              err_d;

  assign rsp_push = rsp_valid && rsp_ready;
  assign rsp_pop  = rsp_tvalid && rsp_tready;

  dti_conv_fifo #(.WIDTH(RSP_EW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (rsp_valid),
    .push_ready (rsp_ready),
    .push_data  ({rsp_payload, rsp_srcid, rsp_last}),
    .pop_valid  (rsp_tvalid),
    .pop_ready  (rsp_tready),
    .pop_data   (rsp_head),
    .full       (rsp_full_unused),
    .empty      (rsp_empty_unused),
    .count      (rsp_count)
  );

  assign {rsp_head_payload, rsp_ttid, rsp_tlast} = rsp_head;
  assign rsp_tdata = rsp_head_payload[PW-1:KEEP_W];
  assign rsp_tkeep = rsp_head_payload[KEEP_W-1:0];

  assign rsp_count_d = rsp_count + (RAW+1)'(rsp_push) - (RAW+1)'(rsp_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_threshold <= 1'b1;
      rsp_state     <= IDLE;
      rsp_src_q     <= '0;
      err_tid       <= 1'b0;
    end else begin
      rsp_threshold <= (rsp_count_d <= THR_LIMIT);
      rsp_state     <= rsp_state_d;
      rsp_src_q     <= rsp_src_d;
      err_tid       <= err_d;
    end
  end

  // A mismatching beat is still stored; the flag only reports it
  always_comb begin
    rsp_state_d = rsp_state;
    rsp_src_d   = rsp_src_q;
    err_d       = err_tid;
    case (rsp_state)
      IDLE: begin
        if (rsp_push && !rsp_last) begin
          rsp_state_d = BURST;
          rsp_src_d   = rsp_srcid;
        end
      end
      BURST: begin
        if (rsp_push) begin
          if (rsp_srcid != rsp_src_q) err_d = 1'b1;
          if (rsp_last) rsp_state_d = IDLE;
        end
      end
    endcase
  end

  logic unused_sink;
  assign unused_sink = ^{rsp_tgtid, rsp_qos, req_full_unused, req_empty_unused,
                         req_count_unused, rsp_full_unused, rsp_empty_unused};

endmodule

// File: tb/tb_dti_gnpd_conv_pipe.sv
// tb/tb_dti_gnpd_conv_pipe.sv - self-checking bench for dti_gnpd_conv_pipe with queue-based reference model
module tb_dti_gnpd_conv_pipe;

  localparam int DW = 80;
  localparam int KW = 10;
  localparam int TW = 6;
  localparam int NW = 6;
  localparam int PW = DW + KW;
  localparam int RSP_DEPTH = 4;
  localparam int RSP_THRESH = 2;

  logic          clk;
  logic          rst_n;
  logic [NW-1:0] cfg_tgtid;
  logic          req_tvalid, req_tready;
  logic [DW-1:0] req_tdata;
  logic [KW-1:0] req_tkeep;
  logic          req_tlast;
  logic [TW-1:0] req_ttid;
  logic          rsp_tvalid, rsp_tready;
  logic [DW-1:0] rsp_tdata;
  logic [KW-1:0] rsp_tkeep;
  logic          rsp_tlast;
  logic [TW-1:0] rsp_ttid;
  logic          req_valid, req_ready;
  logic [PW-1:0] req_payload;
  logic [TW-1:0] req_srcid;
  logic [NW-1:0] req_tgtid;
  logic          req_qos, req_last, req_threshold;
  logic          rsp_valid, rsp_ready;
  logic [PW-1:0] rsp_payload;
  logic [TW-1:0] rsp_srcid;
  logic [NW-1:0] rsp_tgtid;
  logic          rsp_qos, rsp_last;
  logic          rsp_threshold, err_tid;

  dti_gnpd_conv_pipe #(
    .DATA_W(DW), .TID_W(TW), .NODE_W(NW), .REQ_DEPTH(4), .RSP_DEPTH(RSP_DEPTH),
    .RSP_THRESH(RSP_THRESH), .REQ_QOS(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_tgtid(cfg_tgtid),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tlast(req_tlast), .req_ttid(req_ttid),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
    .rsp_tkeep(rsp_tkeep), .rsp_tlast(rsp_tlast), .rsp_ttid(rsp_ttid),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .req_srcid(req_srcid), .req_tgtid(req_tgtid), .req_qos(req_qos),
    .req_last(req_last), .req_threshold(req_threshold),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload(rsp_payload),
    .rsp_srcid(rsp_srcid), .rsp_tgtid(rsp_tgtid), .rsp_qos(rsp_qos),
    .rsp_last(rsp_last), .rsp_threshold(rsp_threshold), .err_tid(err_tid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [PW+TW+NW:0] req_rec_t;  // {payload, srcid, tgtid, last}
  typedef logic [PW+TW:0]    rsp_rec_t;  // {tdata, tkeep, ttid, tlast}

  int       checks;
  int       failures;
  req_rec_t req_exp[$];
  req_rec_t req_obs[$];
  rsp_rec_t rsp_exp[$];
  rsp_rec_t rsp_obs[$];
  int       atomic_viol;
  bit       obs_mid;
  bit       exp_err;
  bit       m_in_pkt;
  logic [TW-1:0] m_pkt_src;
  bit       done_a, done_b;

  // Transfers are recorded half a cycle before the edge that completes them
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid && req_ready) begin
        req_obs.push_back({req_payload, req_srcid, req_tgtid, req_last});
        if (!obs_mid && !req_threshold) atomic_viol++;
        obs_mid = !req_last;
      end
      if (rsp_tvalid && rsp_tready)
        rsp_obs.push_back({rsp_tdata, rsp_tkeep, rsp_ttid, rsp_tlast});
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic logic [PW-1:0] rnd_payload();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic send_req(input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic [TW-1:0] tid, input logic [NW-1:0] tg, input logic last);
    int n;
    n = 0;
    req_tvalid = 1'b1; req_tdata = d; req_tkeep = k; req_ttid = tid;
    req_tlast = last; cfg_tgtid = tg;
    req_exp.push_back({d, k, tid, tg, last});
    @(negedge clk);
    while (!req_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_tready) begin
      failures++;
      $display("FAIL req_accept_timeout got tready=%0b exp 1", req_tready);
    end
    @(posedge clk); #1;
    req_tvalid = 1'b0;
  endtask

  task automatic send_rsp(input logic [PW-1:0] p, input logic [TW-1:0] src, input logic last);
    int n;
    n = 0;
    rsp_valid = 1'b1; rsp_payload = p; rsp_srcid = src; rsp_last = last;
    rsp_tgtid = NW'($urandom); rsp_qos = 1'($urandom);
    rsp_exp.push_back({p, src, last});
    if (m_in_pkt && src != m_pkt_src) exp_err = 1'b1;
    if (!m_in_pkt && !last) begin
      m_in_pkt = 1'b1;
      m_pkt_src = src;
    end else if (last) begin
      m_in_pkt = 1'b0;
    end
    @(negedge clk);
    while (!rsp_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_ready) begin
      failures++;
      $display("FAIL rsp_accept_timeout got ready=%0b exp 1", rsp_ready);
    end
    @(posedge clk); #1;
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_tvalid = 0; req_tdata = '0; req_tkeep = '0; req_tlast = 0; req_ttid = '0; cfg_tgtid = '0;
    rsp_tready = 0; req_ready = 0; req_threshold = 0;
    rsp_valid = 0; rsp_payload = '0; rsp_srcid = '0; rsp_tgtid = '0; rsp_qos = 0; rsp_last = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_tready, rsp_ready, req_valid, rsp_tvalid, rsp_threshold, req_qos, err_tid} !== 7'b1100110) begin
      failures++;
      $display("FAIL reset_outputs got %b exp 1100110",
               {req_tready, rsp_ready, req_valid, rsp_tvalid, rsp_threshold, req_qos, err_tid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    req_ready = 1; req_threshold = 1;
    @(posedge clk); #1;
    req_tvalid = 1; req_tdata = 80'h1234; req_tkeep = 10'h3FF; req_ttid = 6'd5;
    req_tlast = 1; cfg_tgtid = 6'd3;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || req_tready !== 1'b1) begin
      failures++;
      $display("FAIL single_no_bypass got valid=%0b tready=%0b exp 0 1", req_valid, req_tready);
    end
    @(posedge clk); #1;
    req_tvalid = 0;
    @(negedge clk);
    checks++;
    if ({req_valid, req_payload, req_srcid, req_tgtid, req_last} !== {1'b1, 80'h1234, 10'h3FF, 6'd5, 6'd3, 1'b1}) begin
      failures++;
      $display("FAIL single_beat_out got %h exp %h",
               {req_valid, req_payload, req_srcid, req_tgtid, req_last},
               {1'b1, 80'h1234, 10'h3FF, 6'd5, 6'd3, 1'b1});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || req_obs.size() != 1) begin
      failures++;
      $display("FAIL single_popped got valid=%0b n=%0d exp 0 1", req_valid, req_obs.size());
    end
    req_obs.delete();
  endtask

  task automatic test_threshold_gating();
    req_ready = 0; req_threshold = 1;
    @(posedge clk); #1;
    send_req(rnd_data(), KW'($urandom), 6'd1, NW'($urandom), 1'b0);
    send_req(rnd_data(), KW'($urandom), 6'd1, NW'($urandom), 1'b0);
    send_req(rnd_data(), KW'($urandom), 6'd1, NW'($urandom), 1'b1);
    send_req(rnd_data(), KW'($urandom), 6'd2, NW'($urandom), 1'b1);
    req_ready = 1;
    @(posedge clk); #1;
    req_threshold = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (req_obs.size() != 3 || req_valid !== 1'b0) begin
      failures++;
      $display("FAIL threshold_hold got n=%0d valid=%0b exp 3 0", req_obs.size(), req_valid);
    end
    @(posedge clk); #1;
    req_threshold = 1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (req_obs.size() != req_exp.size() || atomic_viol != 0) begin
      failures++;
      $display("FAIL threshold_count got n=%0d viol=%0d exp %0d 0", req_obs.size(), atomic_viol, req_exp.size());
    end
    for (int i = 0; i < req_exp.size(); i++) begin
      checks++;
      if (i >= req_obs.size() || req_obs[i] !== req_exp[i]) begin
        failures++;
        $display("FAIL threshold_beat%0d got %h exp %h", i, req_obs[i], req_exp[i]);
      end
    end
    req_obs.delete(); req_exp.delete();
  endtask

  task automatic test_req_backpressure();
    req_ready = 0; req_threshold = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      send_req(rnd_data(), KW'($urandom), TW'($urandom), NW'($urandom), 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_tready !== 1'b0) begin
      failures++;
      $display("FAIL req_full_tready got %0b exp 0", req_tready);
    end
    @(posedge clk); #1;
    fork
      send_req(rnd_data(), KW'($urandom), TW'($urandom), NW'($urandom), 1'b1);
      begin
        repeat (3) @(negedge clk);
        checks++;
        if (req_tready !== 1'b0 || req_obs.size() != 0) begin
          failures++;
          $display("FAIL req_fifth_held got tready=%0b n=%0d exp 0 0", req_tready, req_obs.size());
        end
        @(posedge clk); #1;
        req_ready = 1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (req_obs.size() != 5) begin
      failures++;
      $display("FAIL backpressure_count got %0d exp 5", req_obs.size());
    end
    for (int i = 0; i < req_exp.size(); i++) begin
      checks++;
      if (i >= req_obs.size() || req_obs[i] !== req_exp[i]) begin
        failures++;
        $display("FAIL backpressure_beat%0d got %h exp %h", i, req_obs[i], req_exp[i]);
      end
    end
    req_obs.delete(); req_exp.delete();
  endtask

  task automatic test_rsp_threshold();
    rsp_tready = 0;
    @(negedge clk);
    checks++;
    if (rsp_threshold !== 1'b1) begin
      failures++;
      $display("FAIL rsp_thr_count0 got %0b exp 1", rsp_threshold);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= RSP_DEPTH; i++) begin
      send_rsp(rnd_payload(), 6'd3, 1'(i == RSP_DEPTH));
      @(negedge clk);
      checks++;
      if (rsp_threshold !== 1'((RSP_DEPTH - i) >= RSP_THRESH)) begin
        failures++;
        $display("FAIL rsp_thr_count%0d got %0b exp %0b", i, rsp_threshold, (RSP_DEPTH - i) >= RSP_THRESH);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (rsp_ready !== 1'b0 || rsp_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL rsp_full got ready=%0b tvalid=%0b exp 0 1", rsp_ready, rsp_tvalid);
    end
    @(posedge clk); #1;
    rsp_tready = 1;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < rsp_exp.size(); i++) begin
      checks++;
      if (i >= rsp_obs.size() || rsp_obs[i] !== rsp_exp[i]) begin
        failures++;
        $display("FAIL rsp_drain_beat%0d got %h exp %h", i, rsp_obs[i], rsp_exp[i]);
      end
    end
    checks++;
    if (rsp_threshold !== 1'b1 || rsp_obs.size() != RSP_DEPTH) begin
      failures++;
      $display("FAIL rsp_drained got thr=%0b n=%0d exp 1 %0d", rsp_threshold, rsp_obs.size(), RSP_DEPTH);
    end
    rsp_obs.delete(); rsp_exp.delete();
  endtask

  task automatic test_random_traffic();
    done_a = 0; done_b = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int p = 0; p < 12; p++) begin
          int len;
          logic [TW-1:0] tid;
          len = $urandom_range(1, 3);
          tid = TW'($urandom);
          for (int b = 0; b < len; b++)
            send_req(rnd_data(), KW'($urandom), tid, NW'($urandom), 1'(b == len - 1));
        end
        done_a = 1;
      end
      begin
        for (int p = 0; p < 12; p++) begin
          int len;
          logic [TW-1:0] src;
          len = $urandom_range(1, 3);
          src = TW'($urandom);
          for (int b = 0; b < len; b++)
            send_rsp(rnd_payload(), src, 1'(b == len - 1));
        end
        done_b = 1;
      end
      begin
        for (int c = 0; c < 3000 && !(done_a && done_b); c++) begin
          @(posedge clk); #1;
          req_ready     = 1'($urandom_range(0, 3) != 0);
          req_threshold = 1'($urandom_range(0, 2) != 0);
          rsp_tready    = 1'($urandom_range(0, 1));
        end
      end
    join
    req_ready = 1; req_threshold = 1; rsp_tready = 1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (req_obs.size() != req_exp.size() || rsp_obs.size() != rsp_exp.size()) begin
      failures++;
      $display("FAIL random_counts got req=%0d rsp=%0d exp %0d %0d",
               req_obs.size(), rsp_obs.size(), req_exp.size(), rsp_exp.size());
    end
    for (int i = 0; i < req_exp.size(); i++) begin
      checks++;
      if (i >= req_obs.size() || req_obs[i] !== req_exp[i]) begin
        failures++;
        $display("FAIL random_req%0d got %h exp %h", i, req_obs[i], req_exp[i]);
      end
    end
    for (int i = 0; i < rsp_exp.size(); i++) begin
      checks++;
      if (i >= rsp_obs.size() || rsp_obs[i] !== rsp_exp[i]) begin
        failures++;
        $display("FAIL random_rsp%0d got %h exp %h", i, rsp_obs[i], rsp_exp[i]);
      end
    end
    checks++;
    if (atomic_viol != 0 || err_tid !== exp_err) begin
      failures++;
      $display("FAIL random_atomic_err got viol=%0d err=%0b exp 0 %0b", atomic_viol, err_tid, exp_err);
    end
    req_obs.delete(); req_exp.delete(); rsp_obs.delete(); rsp_exp.delete();
  endtask

  task automatic test_err_tid();
    rsp_tready = 1;
    @(posedge clk); #1;
    send_rsp(rnd_payload(), 6'd7, 1'b0);
    @(negedge clk);
    checks++;
    if (err_tid !== exp_err) begin
      failures++;
      $display("FAIL err_after_beat1 got %0b exp %0b", err_tid, exp_err);
    end
    @(posedge clk); #1;
    send_rsp(rnd_payload(), 6'd9, 1'b1);
    @(negedge clk);
    checks++;
    if (err_tid !== exp_err || exp_err !== 1'b1) begin
      failures++;
      $display("FAIL err_after_beat2 got %0b exp 1", err_tid);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_tid !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %0b exp 1", err_tid);
    end
    checks++;
    if (rsp_obs.size() != 2 || rsp_obs[0] !== rsp_exp[0] || rsp_obs[1] !== rsp_exp[1]
        || rsp_obs[0][TW:1] !== 6'd7 || rsp_obs[1][TW:1] !== 6'd9) begin
      failures++;
      $display("FAIL err_rsp_ttid got n=%0d %h %h exp %h %h", rsp_obs.size(), rsp_obs[0], rsp_obs[1], rsp_exp[0], rsp_exp[1]);
    end
    rsp_obs.delete(); rsp_exp.delete();
  endtask

  task automatic test_async_reset();
    req_ready = 0; req_threshold = 1; rsp_tready = 0;
    @(posedge clk); #1;
    send_req(rnd_data(), KW'($urandom), 6'd4, 6'd2, 1'b0);
    send_req(rnd_data(), KW'($urandom), 6'd4, 6'd2, 1'b0);
    send_rsp(rnd_payload(), 6'd1, 1'b0);
    send_rsp(rnd_payload(), 6'd2, 1'b0);
    @(negedge clk);
    checks++;
    if ({req_valid, rsp_tvalid, err_tid} !== {1'b1, 1'b1, exp_err}) begin
      failures++;
      $display("FAIL pre_reset_state got %b exp %b", {req_valid, rsp_tvalid, err_tid}, {1'b1, 1'b1, exp_err});
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_tready, rsp_ready, req_valid, rsp_tvalid, rsp_threshold, req_qos, err_tid} !== 7'b1100110) begin
      failures++;
      $display("FAIL async_reset_outputs got %b exp 1100110",
               {req_tready, rsp_ready, req_valid, rsp_tvalid, rsp_threshold, req_qos, err_tid});
    end
    req_exp.delete(); rsp_exp.delete(); req_obs.delete(); rsp_obs.delete();
    exp_err = 0; m_in_pkt = 0; obs_mid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_ready = 1; rsp_tready = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || rsp_tvalid !== 1'b0 || err_tid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_empty got %b exp 000", {req_valid, rsp_tvalid, err_tid});
    end
  endtask

  initial begin
    checks = 0; failures = 0; atomic_viol = 0; obs_mid = 0;
    exp_err = 0; m_in_pkt = 0; m_pkt_src = '0;
    test_reset();
    test_single_beat();
    test_threshold_gating();
    test_req_backpressure();
    test_rsp_threshold();
    test_random_traffic();
    test_err_tid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
